mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: 256 x 16 word memory slave for the ISDU/MAR/MDR bus.
// All strobes are active-low. A write commits once, at the first edge where
// the write strobe is seen low. A read loads Data_out at the first edge where
// the read strobe is seen low, and Data_valid is high on the following cycle.
// Data_out is registered; Bus_err is sticky until reset.
// Optional build macro MEM_RESPONDER_IO_EN: word 0xFFFF becomes an I/O port.
// Reads of 0xFFFF return the synchronised Switches; writes load Hex_out.
// Without the macro, 0xFFFF is an out-of-range address like 0x0100-0xFFFE.
module mem_responder (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_valid,
    output logic        Bus_err,
    input  logic [15:0] Switches,
    output logic [15:0] Hex_out
);

    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        WR_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                bus_err_q, bus_err_d;

    logic [DATA_W-1:0]   ram_q [0:DEPTH-1];
    logic [7:0]          ram_addr;
    logic [DATA_W-1:0]   ram_rdata;
    logic [DATA_W-1:0]   ram_wdata;
    logic                ram_we;

    logic                addr_in_ram;
    logic                addr_is_io;
    logic [DATA_W-1:0]   io_rdata;
    logic [DATA_W-1:0]   rd_word;

`ifdef MEM_RESPONDER_IO_EN
    logic [DATA_W-1:0]   sw_meta_q, sw_meta_d;
    logic [DATA_W-1:0]   sw_sync_q, sw_sync_d;
    logic [DATA_W-1:0]   hex_q, hex_d;
`else
    logic                unused_switches;
`endif

    // Byte-lane merge for writes: an active-low enable selects the new byte.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic              ub_n,
        input logic              lb_n
    );
        lane_merge = {ub_n ? old_w[15:8] : new_w[15:8],
                      lb_n ? old_w[7:0]  : new_w[7:0]};
    endfunction

    // Byte-lane mask for reads: a disabled lane reads back as 0x00.
    function automatic logic [DATA_W-1:0] lane_mask(
        input logic [DATA_W-1:0] w,
        input logic              ub_n,
        input logic              lb_n
    );
        lane_mask = {ub_n ? 8'h00 : w[15:8],
                     lb_n ? 8'h00 : w[7:0]};
    endfunction

    assign ram_addr    = ADDR[7:0];
    assign ram_rdata   = ram_q[ram_addr];
    assign addr_in_ram = (ADDR[15:8] == 8'h00);

`ifdef MEM_RESPONDER_IO_EN
    assign addr_is_io  = (ADDR == 16'hFFFF);
    assign io_rdata    = sw_sync_q;
    assign Hex_out     = hex_q;
`else
    assign addr_is_io      = 1'b0;
    assign io_rdata        = '0;
    assign Hex_out         = 16'h0000;
    assign unused_switches = ^Switches;
`endif

    // Read source select: RAM word, I/O port, or zero for an unmapped address.
    always_comb begin
        rd_word = '0;
        if (addr_in_ram) begin
            rd_word = ram_rdata;
        end else if (addr_is_io) begin
            rd_word = io_rdata;
        end
    end

    // Next-state, read capture, write request and error detection.
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        bus_err_d  = bus_err_q;
        ram_we     = 1'b0;
        ram_wdata  = lane_merge(ram_rdata, Data_in, Mem_UB, Mem_LB);
`ifdef MEM_RESPONDER_IO_EN
        hex_d      = hex_q;
`endif
        if (Mem_CE) begin
            // Deselect always returns to IDLE, whatever access was in progress.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!Mem_WE) begin
                        // A write wins over a simultaneous read strobe, but the
                        // overlap is a protocol error.
                        state_d = WR_HOLD;
                        if (!Mem_OE) begin
                            bus_err_d = 1'b1;
                        end
                        if (addr_in_ram) begin
                            ram_we = 1'b1;
                        end else if (addr_is_io) begin
`ifdef MEM_RESPONDER_IO_EN
                            hex_d = lane_merge(hex_q, Data_in, Mem_UB, Mem_LB);
`endif
                        end else begin
                            bus_err_d = 1'b1;
                        end
                    end else if (!Mem_OE) begin
                        state_d    = RD_DATA;
                        data_out_d = lane_mask(rd_word, Mem_UB, Mem_LB);
                        if (!addr_in_ram && !addr_is_io) begin
                            bus_err_d = 1'b1;
                        end
                    end
                end
                RD_DATA: begin
                    if (Mem_OE) begin
                        state_d = IDLE;
                    end
                end
                WR_HOLD: begin
                    // Long write strobes commit only once, on entry.
                    if (Mem_WE) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control and read-data registers, cleared asynchronously on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            data_out_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // RAM array has no reset; a strobe held low through reset must not commit.
    always_ff @(posedge Clk) begin
        if (ram_we && Reset_n) begin
            ram_q[ram_addr] <= ram_wdata;
        end
    end

`ifdef MEM_RESPONDER_IO_EN
    assign sw_meta_d = Switches;
    assign sw_sync_d = sw_meta_q;

    // Two-flop synchroniser for the board switches and the display register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            hex_q     <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            hex_q     <= hex_d;
        end
    end
`endif

    assign Data_out   = data_out_q;
    assign Data_valid = (state_q == RD_DATA);
    assign Bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of single accesses with
// hand-computed results, followed by hand-written multi-cycle sequences
// (deselect abort, strobe overlap, 0xFFFF handling, out-of-range access,
// reset during an access).
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Mem_CE = 1'b1;
    logic        Mem_OE = 1'b1;
    logic        Mem_WE = 1'b1;
    logic        Mem_UB = 1'b0;
    logic        Mem_LB = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] Data_in = 16'h0000;
    logic [15:0] Switches = 16'hBEEF;
    logic [15:0] Data_out;
    logic        Data_valid;
    logic        Bus_err;
    logic [15:0] Hex_out;

    int tests = 0;
    int fails = 0;

    mem_responder dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Mem_CE     (Mem_CE),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE),
        .Mem_UB     (Mem_UB),
        .Mem_LB     (Mem_LB),
        .ADDR       (ADDR),
        .Data_in    (Data_in),
        .Data_out   (Data_out),
        .Data_valid (Data_valid),
        .Bus_err    (Bus_err),
        .Switches   (Switches),
        .Hex_out    (Hex_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        ub;
        logic        lb;
        int          len;
        logic [15:0] exp_dout;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [15:0] addr, input logic [15:0] din,
                                input logic ub, input logic lb, input int len,
                                input logic [15:0] exp_dout, input logic exp_err, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.din = din; v.ub = ub; v.lb = lb; v.len = len;
        v.exp_dout = exp_dout; v.exp_err = exp_err; v.name = name;
        vecs.push_back(v);
    endfunction

    // Called 1 time unit after a rising edge; returns 1 time unit after an edge
    // with the responder back in IDLE. Data_in is inverted after the first
    // edge so any second commit in the strobe would be visible on readback.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input int len);
        ADDR = a; Data_in = d; Mem_UB = ub; Mem_LB = lb;
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1;
        @(posedge Clk); #1;
        Data_in = ~d;
        repeat (len - 1) begin
            @(posedge Clk); #1;
        end
        Mem_CE = 1'b1; Mem_WE = 1'b1; Data_in = d;
        @(posedge Clk); #1;
    endtask

    task automatic do_read(input logic [15:0] a, input logic ub, input logic lb,
                           input int len, input logic [15:0] exp, input string nm);
        ADDR = a; Mem_UB = ub; Mem_LB = lb;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        @(posedge Clk); #1;
        check({nm, " dout"}, Data_out, exp);
        check({nm, " valid"}, {15'd0, Data_valid}, 16'd1);
        repeat (len - 1) begin
            @(posedge Clk); #1;
        end
        if (len > 1) begin
            check({nm, " valid held"}, {15'd0, Data_valid}, 16'd1);
        end
        Mem_CE = 1'b1; Mem_OE = 1'b1;
        @(posedge Clk); #1;
        check({nm, " valid drop"}, {15'd0, Data_valid}, 16'd0);
        check({nm, " dout held"}, Data_out, exp);
    endtask

    task automatic pulse_reset();
        #2 Reset_n = 1'b0;
        #1 check("reset bus_err", {15'd0, Bus_err}, 16'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: writes and reads inside the RAM window, no errors expected.
        add(1, 16'h0010, 16'h1234, 0, 0, 2, 16'h0000, 0, "wr10");
        add(0, 16'h0010, 16'h0000, 0, 0, 2, 16'h1234, 0, "rd10");
        add(1, 16'h0020, 16'hAAAA, 0, 0, 1, 16'h0000, 0, "wr20a");
        add(1, 16'h0020, 16'h5555, 1, 0, 1, 16'h0000, 0, "wr20lo");
        add(0, 16'h0020, 16'h0000, 0, 0, 1, 16'hAA55, 0, "rd20");
        add(0, 16'h0020, 16'h0000, 0, 1, 1, 16'hAA00, 0, "rd20up");
        add(0, 16'h0020, 16'h0000, 1, 0, 1, 16'h0055, 0, "rd20lo");
        add(1, 16'h00FF, 16'h0F0F, 0, 0, 1, 16'h0000, 0, "wrff");
        add(1, 16'h00FF, 16'hFFFF, 1, 1, 3, 16'h0000, 0, "wrffnone");
        add(0, 16'h00FF, 16'h0000, 0, 0, 1, 16'h0F0F, 0, "rdff");
        add(1, 16'h0000, 16'hA5C3, 0, 0, 1, 16'h0000, 0, "wr00");
        add(1, 16'h0040, 16'h1111, 0, 0, 1, 16'h0000, 0, "wr40");
        add(0, 16'h0000, 16'h0000, 0, 0, 3, 16'hA5C3, 0, "rd00");
        add(0, 16'h0010, 16'h0000, 0, 0, 1, 16'h1234, 0, "rd10b");

        // Reset state.
        #1 Reset_n = 1'b0;
        #1;
        check("rst dout", Data_out, 16'h0000);
        check("rst valid", {15'd0, Data_valid}, 16'd0);
        check("rst err", {15'd0, Bus_err}, 16'd0);
        check("rst hex", Hex_out, 16'h0000);
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].din, vecs[i].ub, vecs[i].lb, vecs[i].len);
                check({vecs[i].name, " valid"}, {15'd0, Data_valid}, 16'd0);
            end else begin
                do_read(vecs[i].addr, vecs[i].ub, vecs[i].lb, vecs[i].len,
                        vecs[i].exp_dout, vecs[i].name);
            end
            check({vecs[i].name, " err"}, {15'd0, Bus_err}, {15'd0, vecs[i].exp_err});
        end

        // Deselect during a read: CE high forces IDLE at the next edge.
        ADDR = 16'h0020; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        @(posedge Clk); #1;
        check("abort valid", {15'd0, Data_valid}, 16'd1);
        Mem_CE = 1'b1;
        @(posedge Clk); #1;
        check("abort valid drop", {15'd0, Data_valid}, 16'd0);
        check("abort dout held", Data_out, 16'hAA55);
        Mem_OE = 1'b1;

        // Read and write strobes together: write wins, error flag sets.
        ADDR = 16'h0030; Data_in = 16'h00FF; Mem_UB = 1'b0; Mem_LB = 1'b0;
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
        @(posedge Clk); #1;
        check("overlap err", {15'd0, Bus_err}, 16'd1);
        check("overlap valid", {15'd0, Data_valid}, 16'd0);
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        @(posedge Clk); #1;
        do_read(16'h0030, 0, 0, 1, 16'h00FF, "rd30");
        check("overlap err sticky", {15'd0, Bus_err}, 16'd1);
        pulse_reset();

        // Word 0xFFFF: I/O port with the option, unmapped without it.
        do_read(16'h0010, 0, 0, 1, 16'h1234, "rd10c");
`ifdef MEM_RESPONDER_IO_EN
        do_read(16'hFFFF, 0, 0, 1, 16'hBEEF, "rdio");
        check("rdio err", {15'd0, Bus_err}, 16'd0);
        do_write(16'hFFFF, 16'h0042, 0, 0, 1);
        check("wrio hex", Hex_out, 16'h0042);
        check("wrio err", {15'd0, Bus_err}, 16'd0);
`else
        do_read(16'hFFFF, 0, 0, 1, 16'h0000, "rdio");
        check("rdio err", {15'd0, Bus_err}, 16'd1);
        do_write(16'hFFFF, 16'h0042, 0, 0, 1);
        check("wrio hex", Hex_out, 16'h0000);
`endif
        pulse_reset();

        // Out-of-range address: read returns zero, write is dropped.
        do_read(16'h0010, 0, 0, 1, 16'h1234, "rd10d");
        do_read(16'h0200, 0, 0, 1, 16'h0000, "rd200");
        check("rd200 err", {15'd0, Bus_err}, 16'd1);
        do_write(16'h0200, 16'h5A5A, 0, 0, 1);
        do_read(16'h0000, 0, 0, 1, 16'hA5C3, "rd00 alias");

        // Reset during RD_DATA, read strobe held through reset.
        ADDR = 16'h0010; Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        @(posedge Clk); #1;
        check("pre-rst valid", {15'd0, Data_valid}, 16'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("mid-rst valid", {15'd0, Data_valid}, 16'd0);
        check("mid-rst dout", Data_out, 16'h0000);
        check("mid-rst err", {15'd0, Bus_err}, 16'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("post-rst valid", {15'd0, Data_valid}, 16'd1);
        check("post-rst dout", Data_out, 16'h1234);
        Mem_CE = 1'b1; Mem_OE = 1'b1;
        @(posedge Clk); #1;

        // Write strobe held while reset is low must never commit.
        Reset_n = 1'b0;
        ADDR = 16'h0040; Data_in = 16'h2222; Mem_CE = 1'b0; Mem_WE = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Mem_CE = 1'b1; Mem_WE = 1'b1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        do_read(16'h0040, 0, 0, 1, 16'h1111, "rd40");
        do_read(16'h0020, 0, 0, 1, 16'hAA55, "rd20 kept");
        do_read(16'h00FF, 0, 0, 1, 16'h0F0F, "rdff kept");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
